// File: rtl/layer_blitter_pkg.sv
// Shared constants and frame-FSM encoding for the layer blitter and layer controller.
package layer_blitter_pkg;

   typedef enum logic [1:0] {
      BLT_IDLE,
      BLT_DRAW,
      BLT_DRAIN,
      BLT_DONE
   } blt_state_e;

   localparam logic [11:0]  BLT_TRANSPARENT_COLOR = 12'hF0F;
   localparam int unsigned  BLT_SCREEN_WIDTH      = 320;
   localparam int unsigned  BLT_SCREEN_HEIGHT     = 180;

endpackage

// File: rtl/blit_delay_line.sv
// Valid + screen-address shift register that tracks pixels while the sprite
// buffer read is in flight.
module blit_delay_line
   import layer_blitter_pkg::*;
#(
   parameter int unsigned DEPTH      = 1,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   output logic                  tail_valid,
   output logic [ADDR_WIDTH-1:0] tail_addr,
   output logic                  busy
);

   logic [DEPTH-1:0]                 valid_q;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         addr_q  <= '0;
      end else begin
         valid_q[0] <= push;
         addr_q[0]  <= push_addr;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign tail_valid = valid_q[DEPTH-1];
   assign tail_addr  = addr_q[DEPTH-1];
   assign busy       = |valid_q;

endmodule

// File: rtl/layer_blitter.sv
// Sprite-to-VRAM blitter: colour-keys and clips pixels from the layer controller,
// issues registered VRAM writes and tracks frame completion and statistics.
module layer_blitter
   import layer_blitter_pkg::*;
#(
   parameter int unsigned            VRAM_A_WIDTH      = 16,
   parameter int unsigned            SPRITEBUF_A_WIDTH = 13,
   parameter int unsigned            COLOR_WIDTH       = 12,
   parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = COLOR_WIDTH'(BLT_TRANSPARENT_COLOR),
   parameter int unsigned            SCREEN_WIDTH      = BLT_SCREEN_WIDTH,
   parameter int unsigned            SCREEN_HEIGHT     = BLT_SCREEN_HEIGHT,
   parameter int unsigned            RD_LATENCY        = 1,
   parameter int unsigned            CNT_WIDTH         = 16
) (
   input  logic                         CLK,
   input  logic                         rst,
   input  logic [VRAM_A_WIDTH-1:0]      i_address_screen,
   input  logic [SPRITEBUF_A_WIDTH-1:0] i_address_s,
   input  logic                         i_is_layer_drawing,
   input  logic [COLOR_WIDTH-1:0]       i_sprite_data,
   output logic [SPRITEBUF_A_WIDTH-1:0] o_sprite_addr,
   output logic                         o_vram_we,
   output logic [VRAM_A_WIDTH-1:0]      o_vram_addr,
   output logic [COLOR_WIDTH-1:0]       o_vram_data,
   output logic                         o_busy,
   output logic                         o_frame_done,
   output logic [CNT_WIDTH-1:0]         o_write_cnt,
   output logic [CNT_WIDTH-1:0]         o_skip_cnt,
   output logic [CNT_WIDTH-1:0]         o_clip_cnt
);

   localparam int unsigned SCREEN_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
   // The falling-edge cycle is the first of the RD_LATENCY+1 drain cycles.
   localparam logic [2:0]  DRAIN_LOAD    = 3'(RD_LATENCY);

   blt_state_e                  state_q;
   logic [2:0]                  drain_q;
   logic                        frame_done_q;
   logic                        vram_we_q;
   logic [VRAM_A_WIDTH-1:0]     vram_addr_q;
   logic [COLOR_WIDTH-1:0]      vram_data_q;
   logic [CNT_WIDTH-1:0]        write_cnt_q, skip_cnt_q, clip_cnt_q;

   logic                        eval_valid;
   logic [VRAM_A_WIDTH-1:0]     eval_addr;
   logic                        pipe_busy;
   logic                        in_range, do_clip, do_skip, do_write, clear_stats;

   blit_delay_line #(
      .DEPTH      (RD_LATENCY),
      .ADDR_WIDTH (VRAM_A_WIDTH)
   ) u_delay_line (
      .clk        (CLK),
      .rst_n      (rst),
      .push       (i_is_layer_drawing),
      .push_addr  (i_address_screen),
      .tail_valid (eval_valid),
      .tail_addr  (eval_addr),
      .busy       (pipe_busy)
   );

   assign in_range    = 32'(eval_addr) < SCREEN_PIXELS;
   assign do_clip     = eval_valid && !in_range;
   assign do_skip     = eval_valid && in_range && (i_sprite_data == TRANSPARENT_COLOR);
   assign do_write    = eval_valid && in_range && (i_sprite_data != TRANSPARENT_COLOR);
   // A new frame's first accepted pair restarts the statistics.
   assign clear_stats = i_is_layer_drawing && (state_q == BLT_IDLE || state_q == BLT_DONE);

   function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] cnt,
                                                 input logic clr, input logic inc);
      logic [CNT_WIDTH-1:0] base;
      base = clr ? '0 : cnt;
      return (inc && base != '1) ? base + CNT_WIDTH'(1) : base;
   endfunction

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         vram_we_q   <= 1'b0;
         vram_addr_q <= '0;
         vram_data_q <= '0;
         write_cnt_q <= '0;
         skip_cnt_q  <= '0;
         clip_cnt_q  <= '0;
      end else begin
         vram_we_q <= do_write;
         if (do_write) begin
            vram_addr_q <= eval_addr;
            vram_data_q <= i_sprite_data;
         end
         write_cnt_q <= bump(write_cnt_q, clear_stats, do_write);
         skip_cnt_q  <= bump(skip_cnt_q, clear_stats, do_skip);
         clip_cnt_q  <= bump(clip_cnt_q, clear_stats, do_clip);
      end
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q      <= BLT_IDLE;
         drain_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            BLT_IDLE: if (i_is_layer_drawing) state_q <= BLT_DRAW;
            BLT_DRAW: begin
               if (!i_is_layer_drawing) begin
                  state_q <= BLT_DRAIN;
                  drain_q <= DRAIN_LOAD;
               end
            end
            BLT_DRAIN: begin
               if (i_is_layer_drawing) begin
                  state_q <= BLT_DRAW;
               end else if (drain_q <= 3'd1) begin
                  state_q      <= BLT_DONE;
                  frame_done_q <= 1'b1;
               end else begin
                  drain_q <= drain_q - 3'd1;
               end
            end
            BLT_DONE: state_q <= i_is_layer_drawing ? BLT_DRAW : BLT_IDLE;
            default:  state_q <= BLT_IDLE;
         endcase
      end
   end

   assign o_sprite_addr = i_address_s;
   assign o_vram_we     = vram_we_q;
   assign o_vram_addr   = vram_addr_q;
   assign o_vram_data   = vram_data_q;
   assign o_frame_done  = frame_done_q;
   assign o_write_cnt   = write_cnt_q;
   assign o_skip_cnt    = skip_cnt_q;
   assign o_clip_cnt    = clip_cnt_q;
   assign o_busy        = (state_q == BLT_DRAW) || (state_q == BLT_DRAIN) || pipe_busy;

endmodule

// File: tb/tb_layer_blitter.sv
// Bench for layer_blitter: a latency-1 instance and a latency-3 / 4-bit-counter instance
// share stimulus; each VRAM write is matched against a scoreboard of expected writes.
module tb_layer_blitter;

   localparam logic [11:0] KEY = 12'hF0F;

   typedef struct {
      logic [15:0] addr;
      logic [11:0] data;
      int          cyc;
   } wr_t;

   logic        CLK   = 1'b0;
   logic        rst   = 1'b0;
   logic [15:0] scr   = '0;
   logic [12:0] saddr = '0;
   logic        draw  = 1'b0;
   logic [12:0] spr_idx = '0;
   logic [11:0] sprite_mem [8192];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int wr_seen_a = 0;
   int wr_seen_b = 0;
   wr_t q_a[$];
   wr_t q_b[$];
   int  done_a_q[$];
   int  done_b_q[$];
   wr_t exp_a, exp_b;

   logic [12:0] spr_a, spr_b;
   logic        we_a, we_b, busy_a, busy_b, done_a, done_b;
   logic [15:0] vaddr_a, vaddr_b;
   logic [11:0] vdata_a, vdata_b;
   logic [15:0] wcnt_a, scnt_a, ccnt_a;
   logic [3:0]  wcnt_b, scnt_b, ccnt_b;
   logic [11:0] rd_a;
   logic [11:0] rd_b [3];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cycle <= cycle + 1;

   // Synchronous sprite buffer models with latency 1 and 3.
   always @(posedge CLK) begin
      rd_a    <= sprite_mem[spr_a];
      rd_b[0] <= sprite_mem[spr_b];
      rd_b[1] <= rd_b[0];
      rd_b[2] <= rd_b[1];
   end

   layer_blitter #(.RD_LATENCY(1), .CNT_WIDTH(16)) u_dut_a (
      .CLK(CLK), .rst(rst), .i_address_screen(scr), .i_address_s(saddr),
      .i_is_layer_drawing(draw), .i_sprite_data(rd_a), .o_sprite_addr(spr_a),
      .o_vram_we(we_a), .o_vram_addr(vaddr_a), .o_vram_data(vdata_a), .o_busy(busy_a),
      .o_frame_done(done_a), .o_write_cnt(wcnt_a), .o_skip_cnt(scnt_a), .o_clip_cnt(ccnt_a)
   );

   layer_blitter #(.RD_LATENCY(3), .CNT_WIDTH(4)) u_dut_b (
      .CLK(CLK), .rst(rst), .i_address_screen(scr), .i_address_s(saddr),
      .i_is_layer_drawing(draw), .i_sprite_data(rd_b[2]), .o_sprite_addr(spr_b),
      .o_vram_we(we_b), .o_vram_addr(vaddr_b), .o_vram_data(vdata_b), .o_busy(busy_b),
      .o_frame_done(done_b), .o_write_cnt(wcnt_b), .o_skip_cnt(scnt_b), .o_clip_cnt(ccnt_b)
   );

   always @(negedge CLK) begin
      if (rst) begin
         if (we_a) begin
            wr_seen_a++;
            checks++;
            if (q_a.size() == 0) begin
               errors++;
               $display("FAIL write_a: unexpected addr %0d data %h at cycle %0d", vaddr_a, vdata_a, cycle);
            end else begin
               exp_a = q_a.pop_front();
               if (vaddr_a !== exp_a.addr || vdata_a !== exp_a.data || cycle != exp_a.cyc) begin
                  errors++;
                  $display("FAIL write_a: got addr %0d data %h cycle %0d, want addr %0d data %h cycle %0d",
                           vaddr_a, vdata_a, cycle, exp_a.addr, exp_a.data, exp_a.cyc);
               end
            end
         end
         if (we_b) begin
            wr_seen_b++;
            checks++;
            if (q_b.size() == 0) begin
               errors++;
               $display("FAIL write_b: unexpected addr %0d data %h at cycle %0d", vaddr_b, vdata_b, cycle);
            end else begin
               exp_b = q_b.pop_front();
               if (vaddr_b !== exp_b.addr || vdata_b !== exp_b.data || cycle != exp_b.cyc) begin
                  errors++;
                  $display("FAIL write_b: got addr %0d data %h cycle %0d, want addr %0d data %h cycle %0d",
                           vaddr_b, vdata_b, cycle, exp_b.addr, exp_b.data, exp_b.cyc);
               end
            end
         end
         if (done_a) done_a_q.push_back(cycle);
         if (done_b) done_b_q.push_back(cycle);
      end
   end

   // Presents one pair this cycle and records the write it should cause.
   task automatic drive_pair(input logic [15:0] a, input logic [11:0] d);
      wr_t e;
      sprite_mem[spr_idx] = d;
      saddr   = spr_idx;
      spr_idx = spr_idx + 13'd1;
      scr     = a;
      draw    = 1'b1;
      if (32'(a) < 57600 && d != KEY) begin
         e.addr = a;
         e.data = d;
         e.cyc  = cycle + 2;
         q_a.push_back(e);
         e.cyc  = cycle + 4;
         q_b.push_back(e);
      end
      @(posedge CLK); #1;
   endtask

   task automatic finish_burst(output int f);
      draw = 1'b0;
      f    = cycle;
      repeat (8) @(posedge CLK);
      #1;
   endtask

   function automatic int first_of(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   task automatic test_reset();
      saddr = 13'h1A5;
      #1;
      checks++;
      if (we_a !== 1'b0 || vaddr_a !== 16'd0 || vdata_a !== 12'd0 || busy_a !== 1'b0 ||
          done_a !== 1'b0 || wcnt_a !== 16'd0 || scnt_a !== 16'd0 || ccnt_a !== 16'd0) begin
         errors++;
         $display("FAIL reset_a: we %b addr %0d data %h busy %b done %b cnt %0d/%0d/%0d, want all 0",
                  we_a, vaddr_a, vdata_a, busy_a, done_a, wcnt_a, scnt_a, ccnt_a);
      end
      checks++;
      if (we_b !== 1'b0 || vaddr_b !== 16'd0 || vdata_b !== 12'd0 || busy_b !== 1'b0 ||
          done_b !== 1'b0 || wcnt_b !== 4'd0 || scnt_b !== 4'd0 || ccnt_b !== 4'd0) begin
         errors++;
         $display("FAIL reset_b: we %b addr %0d data %h busy %b done %b cnt %0d/%0d/%0d, want all 0",
                  we_b, vaddr_b, vdata_b, busy_b, done_b, wcnt_b, scnt_b, ccnt_b);
      end
      checks++;
      if (spr_a !== 13'h1A5 || spr_b !== 13'h1A5) begin
         errors++;
         $display("FAIL sprite_addr_passthrough: got %h/%h, want 1a5", spr_a, spr_b);
      end
      @(posedge CLK); #1;
      rst = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_basic();
      int f;
      done_a_q.delete(); done_b_q.delete();
      drive_pair(16'd0, 12'h123);
      checks++;
      if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b/%b, want 1/1", busy_a, busy_b);
      end
      drive_pair(16'd1, 12'h456);
      drive_pair(16'd2, 12'h789);
      drive_pair(16'd3, 12'hABC);
      finish_burst(f);
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL basic_missing_writes: pending %0d/%0d, want 0/0", q_a.size(), q_b.size());
      end
      checks++;
      if (done_a_q.size() != 1 || first_of(done_a_q) != f + 2) begin
         errors++;
         $display("FAIL basic_done_a: %0d pulses first at %0d, want 1 at %0d",
                  done_a_q.size(), first_of(done_a_q), f + 2);
      end
      checks++;
      if (done_b_q.size() != 1 || first_of(done_b_q) != f + 4) begin
         errors++;
         $display("FAIL basic_done_b: %0d pulses first at %0d, want 1 at %0d",
                  done_b_q.size(), first_of(done_b_q), f + 4);
      end
      checks++;
      if (wcnt_a !== 16'd4 || scnt_a !== 16'd0 || ccnt_a !== 16'd0 || wcnt_b !== 4'd4) begin
         errors++;
         $display("FAIL basic_counts: got w%0d s%0d c%0d wb%0d, want w4 s0 c0 wb4",
                  wcnt_a, scnt_a, ccnt_a, wcnt_b);
      end
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle_busy: got %b/%b, want 0/0", busy_a, busy_b);
      end
   endtask

   task automatic test_transparent();
      int f;
      done_a_q.delete(); done_b_q.delete();
      drive_pair(16'd10, 12'h111);
      drive_pair(16'd11, KEY);
      drive_pair(16'd12, 12'h222);
      drive_pair(16'd13, KEY);
      finish_burst(f);
      checks++;
      if (wcnt_a !== 16'd2 || scnt_a !== 16'd2 || ccnt_a !== 16'd0 ||
          wcnt_b !== 4'd2 || scnt_b !== 4'd2 || ccnt_b !== 4'd0) begin
         errors++;
         $display("FAIL transparent_counts: got a w%0d s%0d c%0d b w%0d s%0d c%0d, want w2 s2 c0",
                  wcnt_a, scnt_a, ccnt_a, wcnt_b, scnt_b, ccnt_b);
      end
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0 || done_a_q.size() != 1 || done_b_q.size() != 1) begin
         errors++;
         $display("FAIL transparent_frame: pending %0d/%0d pulses %0d/%0d, want 0/0 1/1",
                  q_a.size(), q_b.size(), done_a_q.size(), done_b_q.size());
      end
   endtask

   task automatic test_clip();
      int f;
      done_a_q.delete(); done_b_q.delete();
      drive_pair(16'd57599, 12'h5A5);
      drive_pair(16'd57600, 12'h333);
      drive_pair(16'd65535, 12'h444);
      drive_pair(16'd60000, KEY);
      finish_burst(f);
      checks++;
      if (wcnt_a !== 16'd1 || scnt_a !== 16'd0 || ccnt_a !== 16'd3 ||
          wcnt_b !== 4'd1 || scnt_b !== 4'd0 || ccnt_b !== 4'd3) begin
         errors++;
         $display("FAIL clip_counts: got a w%0d s%0d c%0d b w%0d s%0d c%0d, want w1 s0 c3",
                  wcnt_a, scnt_a, ccnt_a, wcnt_b, scnt_b, ccnt_b);
      end
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL clip_missing_writes: pending %0d/%0d, want 0/0", q_a.size(), q_b.size());
      end
   endtask

   task automatic test_reburst();
      int f1, f2;
      done_a_q.delete(); done_b_q.delete();
      for (int i = 0; i < 3; i++) drive_pair(16'(100 + i), 12'(16 + i));
      draw = 1'b0;
      f1   = cycle;
      @(posedge CLK); #1;
      checks++;
      if (busy_b !== 1'b1) begin
         errors++;
         $display("FAIL reburst_gap_busy_b: got %b, want 1", busy_b);
      end
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) drive_pair(16'(110 + i), 12'(32 + i));
      finish_burst(f2);
      checks++;
      if (done_b_q.size() != 1 || first_of(done_b_q) != f2 + 4) begin
         errors++;
         $display("FAIL reburst_done_b: %0d pulses first at %0d, want 1 at %0d",
                  done_b_q.size(), first_of(done_b_q), f2 + 4);
      end
      checks++;
      if (done_a_q.size() != 2 || first_of(done_a_q) != f1 + 2) begin
         errors++;
         $display("FAIL reburst_done_a: %0d pulses first at %0d, want 2 first at %0d",
                  done_a_q.size(), first_of(done_a_q), f1 + 2);
      end
      checks++;
      if (wcnt_b !== 4'd6 || wcnt_a !== 16'd3) begin
         errors++;
         $display("FAIL reburst_counts: got b %0d a %0d, want b 6 a 3", wcnt_b, wcnt_a);
      end
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL reburst_missing_writes: pending %0d/%0d, want 0/0", q_a.size(), q_b.size());
      end
   endtask

   task automatic test_reset_midframe();
      done_a_q.delete(); done_b_q.delete();
      drive_pair(16'd300, 12'h0AA);
      drive_pair(16'd301, 12'h0BB);
      rst  = 1'b0;
      draw = 1'b0;
      q_a.delete(); q_b.delete();
      #1;
      checks++;
      if (we_a !== 1'b0 || vaddr_a !== 16'd0 || vdata_a !== 12'd0 || wcnt_a !== 16'd0 ||
          busy_a !== 1'b0 || we_b !== 1'b0 || wcnt_b !== 4'd0 || scnt_b !== 4'd0 ||
          ccnt_b !== 4'd0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset_outputs: a we%b addr%0d data%h w%0d busy%b b we%b w%0d s%0d c%0d busy%b, want 0",
                  we_a, vaddr_a, vdata_a, wcnt_a, busy_a, we_b, wcnt_b, scnt_b, ccnt_b, busy_b);
      end
      repeat (2) @(posedge CLK);
      #1;
      rst = 1'b1;
      wr_seen_a = 0;
      wr_seen_b = 0;
      repeat (10) @(posedge CLK);
      #1;
      checks++;
      if (wr_seen_a != 0 || wr_seen_b != 0 || done_a_q.size() != 0 || done_b_q.size() != 0) begin
         errors++;
         $display("FAIL midframe_after_reset: writes %0d/%0d pulses %0d/%0d, want 0",
                  wr_seen_a, wr_seen_b, done_a_q.size(), done_b_q.size());
      end
   endtask

   task automatic test_saturation();
      int f;
      done_a_q.delete(); done_b_q.delete();
      wr_seen_a = 0;
      wr_seen_b = 0;
      for (int i = 0; i < 20; i++) drive_pair(16'(200 + i), 12'(i * 7 + 1));
      finish_burst(f);
      checks++;
      if (wcnt_b !== 4'd15 || wcnt_a !== 16'd20) begin
         errors++;
         $display("FAIL saturation_counts: got b %0d a %0d, want b 15 a 20", wcnt_b, wcnt_a);
      end
      checks++;
      if (wr_seen_a != 20 || wr_seen_b != 20 || q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL saturation_writes: seen %0d/%0d pending %0d/%0d, want 20/20 0/0",
                  wr_seen_a, wr_seen_b, q_a.size(), q_b.size());
      end
      checks++;
      if (done_a_q.size() != 1 || done_b_q.size() != 1) begin
         errors++;
         $display("FAIL saturation_done: pulses %0d/%0d, want 1/1", done_a_q.size(), done_b_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) sprite_mem[i] = '0;
      repeat (3) @(posedge CLK);
      #1;
      test_reset();
      test_basic();
      test_transparent();
      test_clip();
      test_reburst();
      test_reset_midframe();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
